// File: rtl/lenet_pkg.sv
// Shared definitions for the lenet run reader: FSM states, activation SRAM
// geometry, per-layer region bases and the readback FIFO entry layout.
package lenet_pkg;

  localparam int unsigned LENET_ACT_DEPTH = 1024;
  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 32;

  // Word offsets of each layer's output region inside activation SRAM
  localparam int unsigned IMG_BASE   = 0;
  localparam int unsigned CONV1_BASE = 256;
  localparam int unsigned CONV2_BASE = 592;
  localparam int unsigned CONV3_BASE = 692;
  localparam int unsigned FC1_BASE   = 722;
  localparam int unsigned FC2_BASE   = 743;
  localparam int unsigned ACT_END    = 753;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_FIN,
    ST_READ,
    ST_DONE
  } state_t;

  // One read-back beat: SRAM address and the word read from it
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rd_entry_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding returned SRAM words until the stream accepts them.
// Entry 0 is always the head, so the head is a plain register.
// Ports: clk, rst_n; i_push/i_data write side; i_pop read side;
//        o_head current head entry, o_count occupancy, o_empty.
module rd_skid_fifo
  import lenet_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  rd_entry_t  i_data,
  input  logic       i_pop,
  output rd_entry_t  o_head,
  output logic [1:0] o_count,
  output logic       o_empty
);

  rd_entry_t  r_ent0;
  rd_entry_t  r_ent1;
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Shift-register storage: pop moves entry 1 into the head slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= i_data;
          else                 r_ent1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_ent0 <= i_data;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_ent0;
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/lenet_run_reader.sv
// Starts a lenet run, times it, then streams a range of activation SRAM
// words out over valid/ready.
// Ports: clk/rst_n; run_req, base_addr, word_count run control; busy, done,
//        timeout, cycle_count status; compute_start/compute_finish to lenet;
//        sram_own + sram_act_* activation port 1; out_* readback stream.
module lenet_run_reader
  import lenet_pkg::*;
#(
  parameter int unsigned ACT_DEPTH = LENET_ACT_DEPTH,
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic [15:0]       base_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              compute_start,
  input  logic              compute_finish,
  output logic              sram_own,
  output logic [3:0]        sram_act_wea1,
  output logic [15:0]       sram_act_addr1,
  output logic [31:0]       sram_act_wdata1,
  input  logic [31:0]       sram_act_rdata1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [15:0]       out_addr,
  output logic              out_last
);

  localparam int unsigned AW = ADDR_W;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_timeout_hit;
  logic             w_last_pop;

  logic [AW-1:0]    r_count;
  logic [AW-1:0]    r_issued;
  logic [AW-1:0]    r_beats;
  logic [AW-1:0]    r_rd_addr;
  logic [AW-1:0]    r_infl_addr;
  logic             r_inflight;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic             r_compute_start;
  logic             r_sram_own;
  logic             r_out_last;

  logic [CNT_W-1:0] w_cycle_inc;
  logic [AW-1:0]    w_rd_addr_inc;
  logic [AW-1:0]    w_beats_nxt;
  logic             w_pop;
  logic             w_issue;
  logic [2:0]       w_occ;
  rd_entry_t        w_head;
  logic [1:0]       w_fifo_count;
  logic             w_fifo_empty;

  assign w_cycle_inc   = r_cycle_count + CNT_W'(1);
  assign w_rd_addr_inc = (r_rd_addr == AW'(ACT_DEPTH - 1)) ? '0 : r_rd_addr + AW'(1);
  assign w_pop         = !w_fifo_empty && out_ready;
  assign w_beats_nxt   = r_beats + AW'(w_pop);

  // Slots committed after this cycle; a pop this cycle frees its slot, which
  // keeps one word per cycle flowing with only two entries of buffering.
  assign w_occ   = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = (r_state == ST_READ) && (r_issued != r_count) && (w_occ < 3'd2);

  // Next-state and control strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_timeout_hit = 1'b0;
    w_last_pop    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (run_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT_FIN;
      ST_WAIT_FIN: begin
        // finish wins if it arrives on the same cycle the limit is reached
        if (compute_finish) begin
          w_state_nxt = (r_count == '0) ? ST_DONE : ST_READ;
        end else if (w_cycle_inc == CNT_W'(TIMEOUT)) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = ST_DONE;
        end
      end
      ST_READ: begin
        w_last_pop = w_pop && (r_beats == r_count - AW'(1));
        if (w_last_pop) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Run bookkeeping, read issue and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count         <= '0;
      r_issued        <= '0;
      r_beats         <= '0;
      r_rd_addr       <= '0;
      r_infl_addr     <= '0;
      r_inflight      <= 1'b0;
      r_cycle_count   <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_timeout       <= 1'b0;
      r_compute_start <= 1'b0;
      r_sram_own      <= 1'b0;
      r_out_last      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count       <= word_count;
        r_rd_addr     <= AW'(32'(base_addr) % ACT_DEPTH);
        r_issued      <= '0;
        r_beats       <= '0;
        r_cycle_count <= '0;
        r_timeout     <= 1'b0;
      end
      if ((r_state == ST_START) || (r_state == ST_WAIT_FIN)) r_cycle_count <= w_cycle_inc;
      if (w_timeout_hit) r_timeout <= 1'b1;

      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_addr <= r_rd_addr;
        r_rd_addr   <= w_rd_addr_inc;
        r_issued    <= r_issued + AW'(1);
      end
      if (w_pop) r_beats <= w_beats_nxt;

      r_busy          <= (w_state_nxt == ST_START) || (w_state_nxt == ST_WAIT_FIN) ||
                         (w_state_nxt == ST_READ);
      r_done          <= (w_state_nxt == ST_DONE);
      r_compute_start <= (w_state_nxt == ST_START);
      r_sram_own      <= (w_state_nxt == ST_READ);
      // Marks that the next beat to leave is the final one
      r_out_last      <= (w_state_nxt == ST_READ) && (w_beats_nxt == r_count - AW'(1));
    end
  end

  rd_skid_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({r_infl_addr, sram_act_rdata1}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  assign busy            = r_busy;
  assign done            = r_done;
  assign timeout         = r_timeout;
  assign cycle_count     = r_cycle_count;
  assign compute_start   = r_compute_start;
  assign sram_own        = r_sram_own;
  assign sram_act_wea1   = 4'b0000;
  assign sram_act_addr1  = r_rd_addr;
  assign sram_act_wdata1 = 32'd0;
  assign out_valid       = !w_fifo_empty;
  assign out_data        = w_head.data;
  assign out_addr        = w_head.addr;
  assign out_last        = r_out_last && !w_fifo_empty;

endmodule

// File: tb/tb_lenet_run_reader.sv
// Bench for lenet_run_reader: lenet finish model, registered SRAM model and
// a queue scoreboard checking every streamed beat.
module tb_lenet_run_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_req;
  logic        to_run_req;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        out_ready;

  logic        busy, done, timeout, compute_start, sram_own, out_valid, out_last;
  logic [31:0] cycle_count, sram_act_wdata1, out_data;
  logic [3:0]  sram_act_wea1;
  logic [15:0] sram_act_addr1, out_addr;
  logic [31:0] sram_act_rdata1 = '0;
  logic        compute_finish;

  logic        to_busy, to_done, to_timeout, to_compute_start, to_sram_own, to_out_valid, to_out_last;
  logic [31:0] to_cycle_count, to_sram_act_wdata1, to_out_data;
  logic [3:0]  to_sram_act_wea1;
  logic [15:0] to_sram_act_addr1, to_out_addr;

  logic [31:0] mem [0:1023];
  logic        model_fin = 1'b0;
  logic        fin_force;
  int          fin_n;
  int          fin_cnt = 0;
  bit          rdy_rand;

  logic [48:0] q_exp [$];
  int n_checks = 0, n_fail = 0;
  int n_starts = 0, n_own = 0, n_done = 0, n_beats = 0;

  always #5 clk = ~clk;

  assign compute_finish = model_fin | fin_force;

  // lenet model: finish rises on the fin_n-th WAIT_FIN cycle (0 = never)
  always @(posedge clk) begin
    if (compute_start) begin
      fin_cnt   <= fin_n - 1;
      model_fin <= (fin_n == 1);
    end else if (fin_cnt > 0) begin
      fin_cnt <= fin_cnt - 1;
      if (fin_cnt == 1) model_fin <= 1'b1;
    end
  end

  // Activation SRAM port 1: data one cycle after address
  always @(posedge clk) sram_act_rdata1 <= mem[sram_act_addr1[9:0]];

  lenet_run_reader u_dut (
    .clk(clk), .rst_n(rst_n), .run_req(run_req), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
    .compute_start(compute_start), .compute_finish(compute_finish),
    .sram_own(sram_own), .sram_act_wea1(sram_act_wea1), .sram_act_addr1(sram_act_addr1),
    .sram_act_wdata1(sram_act_wdata1), .sram_act_rdata1(sram_act_rdata1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last)
  );

  lenet_run_reader #(.TIMEOUT(50)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .run_req(to_run_req), .base_addr(base_addr), .word_count(word_count),
    .busy(to_busy), .done(to_done), .timeout(to_timeout), .cycle_count(to_cycle_count),
    .compute_start(to_compute_start), .compute_finish(1'b0),
    .sram_own(to_sram_own), .sram_act_wea1(to_sram_act_wea1), .sram_act_addr1(to_sram_act_addr1),
    .sram_act_wdata1(to_sram_act_wdata1), .sram_act_rdata1(32'd0),
    .out_valid(to_out_valid), .out_ready(1'b1), .out_data(to_out_data), .out_addr(to_out_addr),
    .out_last(to_out_last)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic        stall_prev = 1'b0;
    logic [47:0] prev = '0;
    logic [48:0] e;
    forever begin
      @(negedge clk);
      if (compute_start) n_starts++;
      if (sram_own) n_own++;
      if (done) n_done++;
      if (rst_n && stall_prev)
        check_eq("stall_hold", 64'({out_valid, out_addr, out_data}), 64'({1'b1, prev}));
      if (rst_n && out_valid && out_ready) begin
        n_beats++;
        if (q_exp.size() == 0) begin
          check_eq("extra_beat", 64'(out_valid), 64'd0);
        end else begin
          e = q_exp.pop_front();
          check_eq("beat", 64'({out_last, out_addr, out_data}), 64'(e));
        end
      end
      stall_prev = rst_n && out_valid && !out_ready;
      prev       = {out_addr, out_data};
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic start_run(input int base, input int cnt);
    int a;
    for (int i = 0; i < cnt; i++) begin
      a = (base + i) % 1024;
      q_exp.push_back({1'(i == cnt - 1), 16'(a), mem[a]});
    end
    @(posedge clk); #1;
    base_addr  = 16'(base);
    word_count = 16'(cnt);
    run_req    = 1'b1;
    @(posedge clk); #1;
    run_req = 1'b0;
  endtask

  // Returns on the negedge where done is high, or after max_cyc cycles
  task automatic wait_done(input string tag, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  // One complete run on the main DUT with end-of-run checks
  task automatic do_run(input string tag, input int base, input int cnt, input int fn,
                        input int exp_cyc, input int budget);
    int s0, b0;
    fin_n = fn;
    s0 = n_starts;
    b0 = n_beats;
    start_run(base, cnt);
    wait_done({tag, "_done"}, budget);
    check_eq({tag, "_cycles"}, 64'(cycle_count), 64'(exp_cyc));
    check_eq({tag, "_starts"}, 64'(n_starts - s0), 64'd1);
    check_eq({tag, "_beats"}, 64'(n_beats - b0), 64'(cnt));
    check_eq({tag, "_q_empty"}, 64'(q_exp.size()), 64'd0);
    check_eq({tag, "_busy_to"}, 64'({busy, timeout}), 64'd0);
  endtask

  initial begin
    int o0, d0, s0, b0, bad, seen, to_starts;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h9E37_79B1);
    rst_n = 1'b0; run_req = 1'b0; to_run_req = 1'b0; base_addr = '0; word_count = '0;
    out_ready = 1'b1; fin_force = 1'b0; fin_n = 0; rdy_rand = 1'b0;
    fork
      monitor();
      ready_drv();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_flags", 64'({busy, done, timeout, compute_start, sram_own, out_valid, out_last}), 64'd0);
    check_eq("rst_cycles", 64'(cycle_count), 64'd0);
    check_eq("rst_addr", 64'({sram_act_addr1, out_addr, sram_act_wea1}), 64'd0);
    check_eq("rst_data", 64'({out_data, sram_act_wdata1}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic FC2 readback, finish 100 cycles after start
    do_run("basic", 743, 10, 100, 101, 400);
    @(negedge clk);
    check_eq("done_pulse", 64'(done), 64'd0);
    check_eq("cycles_hold", 64'(cycle_count), 64'd101);

    // Conv1 region under random backpressure
    rdy_rand = 1'b1;
    do_run("bp", 256, 336, 5, 6, 3000);
    rdy_rand = 1'b0;

    // Zero count: no beats, SRAM never owned
    o0 = n_own;
    do_run("zero", 300, 0, 2, 3, 100);
    check_eq("zero_own", 64'(n_own - o0), 64'd0);

    // Address wrap at the top of activation SRAM
    do_run("wrap", 1020, 8, 1, 2, 100);

    // Timeout instance: finish never comes
    @(posedge clk); #1;
    base_addr = 16'd100; word_count = 16'd4; to_run_req = 1'b1;
    @(posedge clk); #1 to_run_req = 1'b0;
    bad = 0; seen = 0; to_starts = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (to_sram_own || to_out_valid) bad++;
      if (to_compute_start) to_starts++;
      seen = int'(to_done);
    end
    check_eq("to_done", 64'(seen), 64'd1);
    check_eq("to_flag", 64'({to_timeout, to_busy}), 64'b10);
    check_eq("to_cycles", 64'(to_cycle_count), 64'd50);
    check_eq("to_no_reads", 64'(bad), 64'd0);
    check_eq("to_starts", 64'(to_starts), 64'd1);
    @(negedge clk);
    check_eq("to_sticky", 64'({to_timeout, to_done, to_busy}), 64'b100);
    check_eq("to_addr", 64'(to_sram_act_addr1), 64'd100);
    check_eq("to_quiet", 64'({to_sram_act_wea1, to_sram_act_wdata1, to_out_last, to_out_addr[7:0]}) |
                         64'(to_out_data), 64'd0);

    // Finish already high in START, run_req during busy and during DONE
    fin_force = 1'b1;
    fin_n = 0;
    s0 = n_starts;
    b0 = n_beats;
    start_run(700, 3);
    @(posedge clk); #1;
    base_addr = 16'd5; word_count = 16'd1; run_req = 1'b1;
    @(posedge clk); #1 run_req = 1'b0;
    wait_done("busy_done", 100);
    check_eq("busy_cycles", 64'(cycle_count), 64'd2);
    check_eq("busy_beats", 64'(n_beats - b0), 64'd3);
    run_req = 1'b1;
    @(posedge clk); #1 run_req = 1'b0;
    fin_force = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("busy_starts", 64'(n_starts - s0), 64'd1);
    check_eq("busy_idle", 64'({busy, done}), 64'd0);
    check_eq("busy_q_empty", 64'(q_exp.size()), 64'd0);

    // Reset in the middle of a Conv2 readback
    fin_n = 3;
    b0 = n_beats;
    start_run(592, 50);
    seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      @(negedge clk);
      if (n_beats - b0 >= 5) seen = 1;
    end
    check_eq("mid_beats_seen", 64'(seen), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q_exp.delete();
    d0 = n_done;
    @(negedge clk);
    check_eq("mid_rst_flags", 64'({busy, done, timeout, compute_start, sram_own, out_valid, out_last}), 64'd0);
    check_eq("mid_rst_vals", 64'({cycle_count, sram_act_addr1, out_addr}), 64'd0);
    check_eq("mid_rst_data", 64'(out_data), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_no_done", 64'(n_done - d0), 64'd0);
    do_run("post_rst", 722, 21, 4, 5, 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lenet_run_reader.md
Name: lenet_run_reader

Overview:
- Hardware initiator for the lenet core, sitting between a host/debug port and lenet.
- Issues the compute_start pulse, waits for compute_finish and counts run cycles.
- Then reads a programmed address range from activation SRAM port 1 (base 256 = Conv1 … 752 = FC2 end) and streams each word out on a valid/ready interface.
- Replaces bench-side polling and validation with on-chip readback.

Parameters:
ACT_DEPTH, 1024, activation SRAM depth in words; read address wraps modulo ACT_DEPTH
TIMEOUT, 50000, max cycles to wait for compute_finish before aborting
CNT_W, 32, width of cycle_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run_req  in  1  one-cycle request to start a run; ignored while busy
base_addr  in  16  first activation word to read; sampled on run accept
word_count  in  16  number of words to read; sampled on run accept
busy  out  1  high from run accept until done
done  out  1  one-cycle pulse at end of run
timeout  out  1  sticky until next run accept; set if TIMEOUT reached
cycle_count  out  CNT_W  run length in cycles; holds after done
compute_start  out  1  one-cycle start pulse to lenet
compute_finish  in  1  lenet completion level
sram_own  out  1  high only in READ; external mux gives this block act port 1
sram_act_wea1  out  4  always 4'b0 (read-only)
sram_act_addr1  out  16  read address
sram_act_wdata1  out  32  always 0
sram_act_rdata1  in  32  read data, valid one cycle after address
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  32  activation word
out_addr  out  16  SRAM address of out_data
out_last  out  1  high on final beat

Behaviour:
- Reset values: all outputs 0; state IDLE; buffer empty; counters 0.
- State IDLE:
  - run_req=1 accepts the run: latch base_addr and word_count, clear cycle_count and timeout, set busy, go to START.
- State START:
  - compute_start=1 for exactly this cycle; go to WAIT_FIN.
- State WAIT_FIN:
  - cycle_count increments every cycle in START and WAIT_FIN, including the cycle compute_finish is sampled high.
  - Example: finish high on the first WAIT_FIN cycle gives cycle_count=2.
  - compute_finish sampled high: go to READ, or to DONE if word_count=0.
  - cycle_count reaches TIMEOUT first: set timeout, go to DONE, perform no reads.
- State READ:
  - sram_own=1.
  - Issue address base+i (mod ACT_DEPTH) for i = 0..word_count-1.
  - Issue only when (buffered entries + in-flight reads) < 2.
  - Returned rdata goes into a 2-entry FIFO that drives out_*.
  - A beat transfers when out_valid & out_ready.
  - Full throughput (1 word/cycle) when out_ready stays high.
  - out_valid never drops without a transfer; out_data and out_addr stay stable while stalled.
  - out_last=1 exactly on beat word_count-1.
  - Go to DONE after the last beat transfers.
- State DONE:
  - done=1 for one cycle, busy=0 in the same cycle; go to IDLE.
- Simultaneous events:
  - compute_finish already high in START is not sampled; only WAIT_FIN samples it.
  - run_req during busy or DONE is dropped.
  - Address wrap: base 1020, count 8 reads 1020..1023, 0..3.
- Reset mid-operation: returns to IDLE; in-flight read discarded; FIFO flushed; no done pulse.

Decomposition:
- Package lenet_pkg: state enum (IDLE, START, WAIT_FIN, READ, DONE), ACT_DEPTH, region base constants (IMG 0, CONV1 256, CONV2 592, CONV3 692, FC1 722, FC2 743, END 753).
- One sub-module: rd_skid_fifo (2-entry, 48-bit {addr,data}, push/pop, full/empty counts).

Test Plan:
- Basic run: run_req, base 743, count 10; lenet model asserts finish 100 cycles after start → one compute_start pulse, cycle_count=101, 10 beats addresses 743..752 matching RAM, out_last on beat 9, done pulse.
- Backpressure: base 256, count 336; out_ready toggles 1-0-0-1 randomly → data in order, stable during stall, no loss or duplication, ≤2 reads outstanding.
- Zero count and wrap: count 0 gives done with no beats and sram_own never high; base 1020, count 8 gives addresses 1020..1023, 0..3.
- Timeout: TIMEOUT=50 and finish never asserted → timeout=1, cycle_count=50, no reads, done pulse.
- Reset mid-READ: assert rst_n=0 after 5 beats → all outputs 0 next edge, no done; a new run afterwards completes correctly.
- run_req while busy and finish high during START: ignored, and finish is counted only from WAIT_FIN.
